// File: rtl/led_status_ctrl_if.sv
// Input/output bundle for led_status_ctrl. Signals are level-sampled every
// clock with no valid/ready handshake: the game FSM holds its outputs steady.
interface led_status_ctrl_if #(
  parameter int NUM_LEDS = 10,
  parameter int HEALTH_W = 3
);
  logic [2:0]          game_state;
  logic [HEALTH_W-1:0] p1_health;
  logic [HEALTH_W-1:0] p2_health;
  logic [NUM_LEDS-1:0] LEDvalues;

  modport master (output game_state, p1_health, p2_health, input LEDvalues);
  modport slave  (input game_state, p1_health, p2_health, output LEDvalues);
endinterface

// File: rtl/led_status_ctrl.sv
// LED status display: health bars with hit flash in FIGHT, blinking in
// COUNTDOWN/EQ and a one-hot chaser in the win states.
module led_status_ctrl #(
  parameter int NUM_LEDS    = 10,
  parameter int HEALTH_W    = 3,
  parameter int MAX_HEALTH  = 3,
  parameter int TICK_DIV    = 25000000,
  parameter int FLASH_TICKS = 4
) (
  input logic               clk,
  input logic               rst,
  led_status_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    GS_IDLE      = 3'd0,
    GS_COUNTDOWN = 3'd1,
    GS_FIGHT     = 3'd2,
    GS_P1_WIN    = 3'd3,
    GS_P2_WIN    = 3'd4,
    GS_EQ        = 3'd5
  } gs_e;

  localparam int PW = $clog2(TICK_DIV);
  localparam int FW = $clog2(FLASH_TICKS + 1);
  localparam logic [HEALTH_W-1:0] HMAX       = HEALTH_W'(MAX_HEALTH);
  localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0]       FLASH_LOAD = FW'(FLASH_TICKS);
  localparam logic [NUM_LEDS-1:0] LSB_ONE    = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] MSB_ONE    = {1'b1, {(NUM_LEDS-1){1'b0}}};

  function automatic logic [HEALTH_W-1:0] sat(input logic [HEALTH_W-1:0] h);
    return (h > HMAX) ? HMAX : h;
  endfunction

  function automatic logic [MAX_HEALTH-1:0] bar(input logic [HEALTH_W-1:0] h);
    logic [MAX_HEALTH-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_HEALTH; i++) begin
      if (i < int'(h)) b[MAX_HEALTH-1-i] = 1'b1;
    end
    return b;
  endfunction

  gs_e                  gs_cur;
  gs_e                  gs_prev_q, gs_prev_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 blink_q, blink_d;
  logic [NUM_LEDS-1:0]  chase_q, chase_d;
  logic [FW-1:0]        f1_q, f1_d, f2_q, f2_d;
  logic [HEALTH_W-1:0]  h1_prev_q, h1_prev_d, h2_prev_q, h2_prev_d;
  logic [HEALTH_W-1:0]  h1_sat, h2_sat;
  logic [MAX_HEALTH-1:0] bar1, bar2;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic                 tick, state_change;

  always_comb begin
    gs_cur       = (bus.game_state > 3'd5) ? GS_IDLE : gs_e'(bus.game_state);
    h1_sat       = sat(bus.p1_health);
    h2_sat       = sat(bus.p2_health);
    state_change = (gs_cur != gs_prev_q);
    tick         = (presc_q == PRESC_LAST);

    gs_prev_d = gs_cur;
    h1_prev_d = h1_sat;
    h2_prev_d = h2_sat;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    blink_d   = blink_q ^ tick;
    chase_d   = chase_q;
    f1_d      = f1_q;
    f2_d      = f2_q;

    if (tick) begin
      if (gs_cur == GS_P1_WIN) chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
      if (gs_cur == GS_P2_WIN) chase_d = {chase_q[0], chase_q[NUM_LEDS-1:1]};
      if (f1_q != '0) f1_d = f1_q - FW'(1);
      if (f2_q != '0) f2_d = f2_q - FW'(1);
    end

    // A fresh hit always wins over the tick decrement, so repeated hits extend the flash.
    if (gs_cur == GS_FIGHT) begin
      if (h1_sat < h1_prev_q) f1_d = FLASH_LOAD;
      if (h2_sat < h2_prev_q) f2_d = FLASH_LOAD;
    end

    // Entering any state restarts every animation from a known phase.
    if (state_change) begin
      presc_d = '0;
      blink_d = 1'b0;
      chase_d = (gs_cur == GS_P2_WIN) ? MSB_ONE : LSB_ONE;
      f1_d    = '0;
      f2_d    = '0;
    end

    bar1 = bar(h1_sat);
    bar2 = bar(h2_sat);
    if (f1_d != '0) bar1 = bar1 & {MAX_HEALTH{blink_d}};
    if (f2_d != '0) bar2 = bar2 & {MAX_HEALTH{blink_d}};

    led_d = '0;
    case (gs_cur)
      GS_COUNTDOWN, GS_EQ: led_d = {NUM_LEDS{blink_d}};
      GS_FIGHT: begin
        led_d[NUM_LEDS-1 -: MAX_HEALTH] = bar1;
        led_d[MAX_HEALTH-1:0]           = bar2;
      end
      GS_P1_WIN, GS_P2_WIN: led_d = chase_d;
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gs_prev_q <= GS_IDLE;
      presc_q   <= '0;
      blink_q   <= 1'b0;
      chase_q   <= '0;
      f1_q      <= '0;
      f2_q      <= '0;
      h1_prev_q <= '0;
      h2_prev_q <= '0;
      led_q     <= '0;
    end else begin
      gs_prev_q <= gs_prev_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      chase_q   <= chase_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      h1_prev_q <= h1_prev_d;
      h2_prev_q <= h2_prev_d;
      led_q     <= led_d;
    end
  end

  assign bus.LEDvalues = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl with a behavioural reference model
// feeding an expected-value queue.
module tb_led_status_ctrl;
  localparam int NL = 10;
  localparam int HW = 3;
  localparam int MH = 3;
  localparam int TD = 4;
  localparam int FT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_status_ctrl_if #(.NUM_LEDS(NL), .HEALTH_W(HW)) bus();

  led_status_ctrl #(
    .NUM_LEDS(NL), .HEALTH_W(HW), .MAX_HEALTH(MH), .TICK_DIV(TD), .FLASH_TICKS(FT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NL-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_prev_gs, m_cnt, m_pos, m_f1, m_f2, m_h1p, m_h2p;
  bit m_blink;

  task automatic check_eq(input string tag, input logic [NL-1:0] got, input logic [NL-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_prev_gs = 0; m_cnt = 0; m_pos = 0; m_f1 = 0; m_f2 = 0;
    m_h1p = 0; m_h2p = 0; m_blink = 1'b0;
  endtask

  function automatic int sat(input int h);
    return (h > MH) ? MH : h;
  endfunction

  function automatic logic [MH-1:0] bar(input int h);
    logic [MH-1:0] b;
    b = MH'(((1 << h) - 1) << (MH - h));
    return b;
  endfunction

  function automatic logic [NL-1:0] model_edge(input int gs, input int h1, input int h2);
    int g, s1, s2;
    bit tk;
    logic [MH-1:0] b1, b2;
    logic [NL-1:0] e;
    g  = (gs > 5) ? 0 : gs;
    s1 = sat(h1);
    s2 = sat(h2);
    if (g != m_prev_gs) begin
      m_cnt = 0; m_blink = 1'b0; m_f1 = 0; m_f2 = 0;
      m_pos = (g == 4) ? NL - 1 : 0;
    end else begin
      tk = (m_cnt == TD - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      if (tk) begin
        m_blink = !m_blink;
        if (g == 3) m_pos = (m_pos + 1) % NL;
        if (g == 4) m_pos = (m_pos + NL - 1) % NL;
        if (m_f1 > 0) m_f1--;
        if (m_f2 > 0) m_f2--;
      end
      if (g == 2 && s1 < m_h1p) m_f1 = FT;
      if (g == 2 && s2 < m_h2p) m_f2 = FT;
    end
    m_prev_gs = g; m_h1p = s1; m_h2p = s2;
    e = '0;
    case (g)
      1, 5: e = m_blink ? '1 : '0;
      2: begin
        b1 = bar(s1);
        b2 = bar(s2);
        if (m_f1 > 0 && !m_blink) b1 = '0;
        if (m_f2 > 0 && !m_blink) b2 = '0;
        e = {b1, {(NL-2*MH){1'b0}}, b2};
      end
      3, 4: e = NL'(1 << m_pos);
      default: e = '0;
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs, predict the edge, then compare after it.
  task automatic step(input int gs, input int h1, input int h2);
    bus.game_state = 3'(gs);
    bus.p1_health  = HW'(h1);
    bus.p2_health  = HW'(h2);
    exp_q.push_back(model_edge(gs, h1, h2));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check_eq("sb_empty", bus.LEDvalues, 'x);
    else check_eq("led", bus.LEDvalues, exp_q.pop_front());
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_async", bus.LEDvalues, '0);
    @(posedge clk);
    #1;
    check_eq("rst_held", bus.LEDvalues, '0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int gs, h1, h2, len;
    rst = 1'b1;
    bus.game_state = '0;
    bus.p1_health  = '0;
    bus.p2_health  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_idle", bus.LEDvalues, '0);
    rst = 1'b0;
    repeat (3) step(0, 0, 0);

    // FIGHT bars and saturation
    step(2, 3, 1);
    check_eq("fight_bars", bus.LEDvalues, 10'b1110000100);
    step(2, 7, 1);
    check_eq("fight_sat", bus.LEDvalues, 10'b1110000100);

    // hit flash, re-hit mid-flash, increases, simultaneous hits
    repeat (2) step(2, 7, 3);
    repeat (6) step(2, 7, 2);
    repeat (14) step(2, 7, 1);
    repeat (6) step(2, 2, 3);
    repeat (12) step(2, 1, 2);

    // COUNTDOWN phase, then restart via EQ
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      check_eq("cd_phase", bus.LEDvalues, ((i / TD) % 2) ? '1 : '0);
    end
    repeat (6) step(5, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      check_eq("cd_restart", bus.LEDvalues, ((i / TD) % 2) ? '1 : '0);
    end

    // win chasers with wrap
    for (int i = 0; i < 44; i++) begin
      step(3, 0, 0);
      check_eq("p1_chase", bus.LEDvalues, NL'(1 << ((i / TD) % NL)));
    end
    for (int i = 0; i < 44; i++) begin
      step(4, 0, 0);
      check_eq("p2_chase", bus.LEDvalues, NL'(1 << (NL - 1 - (i / TD) % NL)));
    end
    repeat (5) step(4, 0, 0);
    pulse_reset();
    step(4, 0, 0);
    check_eq("p2_restart", bus.LEDvalues, 10'h200);
    repeat (6) step(4, 0, 0);

    // reset mid-flash leaves a solid bar
    repeat (2) step(2, 3, 3);
    repeat (2) step(2, 2, 3);
    pulse_reset();
    step(2, 2, 3);
    check_eq("flash_abort", bus.LEDvalues, 10'b1100000111);
    repeat (8) step(2, 2, 3);

    // encodings 6 and 7 behave as IDLE
    step(6, 3, 3);
    check_eq("gs6_idle", bus.LEDvalues, '0);
    step(7, 3, 3);
    check_eq("gs7_idle", bus.LEDvalues, '0);

    // random segments
    h1 = 3; h2 = 3;
    for (int seg = 0; seg < 40; seg++) begin
      gs  = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) gs = 2;
      len = $urandom_range(3, 30);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) h1 = $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) h2 = $urandom_range(0, 7);
        step(gs, h1, h2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 10, meaning the LED bus width; legal when NUM_LEDS >= 2*MAX_HEALTH.
REQ-002 The block SHALL have parameter HEALTH_W, default 3, meaning the health input width.
REQ-003 The block SHALL have parameter MAX_HEALTH, default 3, meaning the health-bar length per player in LEDs.
REQ-004 The block SHALL have parameter TICK_DIV, default 25000000, meaning clk cycles per animation tick (>= 2).
REQ-005 The block SHALL have parameter FLASH_TICKS, default 4, meaning hit-flash duration in ticks (>= 1).
REQ-006 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port game_state SHALL be an input, 3 bits, encoded 0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 P1_WIN, 4 P2_WIN, 5 EQ; values 6-7 behave as IDLE.
REQ-009 Port p1_health SHALL be an input, HEALTH_W bits: player 1 remaining lives.
REQ-010 Port p2_health SHALL be an input, HEALTH_W bits: player 2 remaining lives.
REQ-011 Port LEDvalues SHALL be an output, NUM_LEDS bits, registered: LED drive, bit NUM_LEDS-1 leftmost.

Function
REQ-012 The tick prescaler SHALL count 0..TICK_DIV-1, then wrap, emitting a one-cycle internal tick when it wraps to 0.
REQ-013 The blink phase SHALL toggle on every tick.
REQ-014 When game_state differs from its value registered on the previous cycle, the block SHALL clear the prescaler, blink phase, chaser and both flash counters on that edge, so animations restart in a known phase.
REQ-015 Health above MAX_HEALTH SHALL saturate to MAX_HEALTH for display.
REQ-016 Bar(h) SHALL be a MAX_HEALTH-bit field whose top h bits are 1 and whose remaining bits are 0.
REQ-017 IDLE: LEDvalues SHALL be all 0.
REQ-018 COUNTDOWN and EQ: all LEDvalues bits SHALL equal the blink phase.
REQ-019 FIGHT: LEDvalues[NUM_LEDS-1 -: MAX_HEALTH] SHALL be Bar(p1), LEDvalues[MAX_HEALTH-1:0] SHALL be Bar(p2), and all middle bits SHALL be 0.
REQ-020 FIGHT hit flash: a decrease in a player's saturated health versus its registered previous value SHALL load that player's flash counter with FLASH_TICKS.
REQ-021 While a flash counter is nonzero, that player's bar SHALL be ANDed with the blink phase.
REQ-022 A nonzero flash counter SHALL decrement once per tick.
REQ-023 A decrease during an active flash SHALL reload the flash counter to FLASH_TICKS; increases SHALL NOT trigger a flash.
REQ-024 Simultaneous decreases by both players SHALL flash both bars independently.
REQ-025 P1_WIN: LEDvalues SHALL be a one-hot chaser starting at bit 0 and shifting one position toward the MSB per tick, wrapping from NUM_LEDS-1 to 0.
REQ-026 P2_WIN: the one-hot chaser SHALL start at bit NUM_LEDS-1 and shift toward the LSB per tick, wrapping from 0 to NUM_LEDS-1.
REQ-027 Output latency SHALL be exactly one clk cycle from an input change (or tick) to the corresponding LEDvalues change.
REQ-028 The block SHALL never drive more than one LEDvalues bit in the win states.

Reset
REQ-029 While rst is high, LEDvalues, the prescaler, blink phase, chaser, flash counters and the previous-state/previous-health registers SHALL be 0 immediately, independent of clk.
REQ-030 The first tick after rst deasserts SHALL occur TICK_DIV cycles later.
REQ-031 Reset asserted mid-animation or mid-flash SHALL abort that animation or flash with no residual effect.

Verification (NUM_LEDS=10, MAX_HEALTH=3, TICK_DIV=4, FLASH_TICKS=2)
REQ-032 Scenario: rst pulse, then game_state=0 -> LEDvalues=0 during and after reset.
REQ-033 Scenario: FIGHT with p1=3, p2=1 -> LEDvalues=10'b1110000100 one cycle later; p1=7 -> still 111 on the left.
REQ-034 Scenario: FIGHT p2 3->2 -> right bar alternates 000/110 each tick for 2 ticks, then holds 110; a second drop mid-flash extends the flash by 2 ticks from the drop.
REQ-035 Scenario: COUNTDOWN entered -> LEDvalues 0 for 4 cycles, then all-1 for 4 cycles, repeating; re-entering the state restarts at 0.
REQ-036 Scenario: P1_WIN -> LEDvalues 0x001, 0x002 ... 0x200, then 0x001, changing every 4 cycles; P2_WIN starts at 0x200 and moves downward.
REQ-037 Scenario: rst asserted mid-P2_WIN chaser -> LEDvalues=0 asynchronously; after release with game_state=4, the chaser restarts at 0x200.
